// File: rtl/btn_pkg.sv
// Shared constants and types for the push-button conditioner.
// Default timing targets the 12 MHz board clock.
package btn_pkg;

    localparam int CLK_HZ = 12_000_000;

    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int DEF_DEBOUNCE      = ms_to_cycles(10);
    localparam int DEF_REPEAT_DELAY  = ms_to_cycles(500);
    localparam int DEF_REPEAT_PERIOD = ms_to_cycles(100);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } rep_state_t;

endpackage

// File: rtl/btn_conditioner_if.sv
// Button pins in, conditioned levels and pulses out.
// The master side drives the pins; the conditioner is the slave.
interface btn_conditioner_if #(
    parameter int N_BTN = 2
);
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_repeat;
    logic [N_BTN-1:0] btn_step;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_repeat,
        input  btn_step
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat,
        output btn_step
    );

endinterface

// File: rtl/btn_conditioner_chan.sv
// One button channel: 2-FF synchroniser, debounce counter and
// auto-repeat FSM producing level, press/release/repeat/step pulses.
module btn_debounce_chan
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat,
    output logic o_step
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int RC_MAX = max2(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int RC_W   = $clog2(RC_MAX + 1);
    localparam bit RPT_EN = (REPEAT_DELAY != 0);

    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE   = DB_W'(1);
    localparam logic [RC_W-1:0] RC_ONE   = RC_W'(1);
    localparam logic [RC_W-1:0] PER_LAST = RC_W'(REPEAT_PERIOD - 1);
    localparam logic [RC_W-1:0] DLY_LAST =
        RC_W'(RPT_EN ? REPEAT_DELAY - 1 : 0);

    logic [1:0]      r_sync;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_level;
    logic            r_press;
    logic            r_release;
    logic            r_repeat;
    logic            r_step;
    rep_state_t      r_state;
    logic [RC_W-1:0] r_rcnt;

    logic            w_sync;
    logic            w_diff;
    logic            w_flip;
    logic            w_rise;
    logic            w_fall;
    rep_state_t      w_state_nxt;
    logic [RC_W-1:0] w_rcnt_nxt;
    logic            w_rep_nxt;

    assign w_sync = r_sync[1];
    assign w_diff = w_sync ^ r_level;
    assign w_flip = w_diff && (r_db_cnt == DB_LAST);
    assign w_rise = w_flip & ~r_level;
    assign w_fall = w_flip & r_level;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_btn};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_db_cnt <= '0;
            r_level  <= 1'b0;
        end else if (!w_diff) begin
            r_db_cnt <= '0;
        end else if (w_flip) begin
            r_db_cnt <= '0;
            r_level  <= ~r_level;
        end else begin
            r_db_cnt <= r_db_cnt + DB_ONE;
        end
    end

    // A release on the same edge as a repeat expiry suppresses the repeat.
    always_comb begin
        w_state_nxt = r_state;
        w_rcnt_nxt  = r_rcnt;
        w_rep_nxt   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt = HOLD;
                    w_rcnt_nxt  = '0;
                end
            end
            HOLD: begin
                if (RPT_EN) begin
                    if (r_rcnt == DLY_LAST) begin
                        w_rep_nxt   = 1'b1;
                        w_state_nxt = REPEAT;
                        w_rcnt_nxt  = '0;
                    end else begin
                        w_rcnt_nxt = r_rcnt + RC_ONE;
                    end
                end
            end
            REPEAT: begin
                if (r_rcnt == PER_LAST) begin
                    w_rep_nxt  = 1'b1;
                    w_rcnt_nxt = '0;
                end else begin
                    w_rcnt_nxt = r_rcnt + RC_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_rcnt_nxt  = '0;
            end
        endcase
        if (w_fall) begin
            w_state_nxt = IDLE;
            w_rcnt_nxt  = '0;
            w_rep_nxt   = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_rcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rcnt  <= w_rcnt_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
            r_step    <= 1'b0;
        end else begin
            r_press   <= w_rise;
            r_release <= w_fall;
            r_repeat  <= w_rep_nxt;
            r_step    <= r_press | r_repeat;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_repeat  = r_repeat;
    assign o_step    = r_step;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button input stage: N_BTN independent conditioned channels
// feeding the blink-rate logic through btn_step.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic               sysclk,
    input  logic               rst_n,
    btn_conditioner_if.slave   bus
);

    logic [N_BTN-1:0] w_level;
    logic [N_BTN-1:0] w_press;
    logic [N_BTN-1:0] w_release;
    logic [N_BTN-1:0] w_repeat;
    logic [N_BTN-1:0] w_step;

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        btn_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .i_clk     (sysclk),
            .i_rst_n   (rst_n),
            .i_btn     (bus.btn_in[g]),
            .o_level   (w_level[g]),
            .o_press   (w_press[g]),
            .o_release (w_release[g]),
            .o_repeat  (w_repeat[g]),
            .o_step    (w_step[g])
        );
    end

    assign bus.btn_level   = w_level;
    assign bus.btn_press   = w_press;
    assign bus.btn_release = w_release;
    assign bus.btn_repeat  = w_repeat;
    assign bus.btn_step    = w_step;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: vector table, corner sequences and a
// random run compared cycle by cycle with a sliding-window model.
module tb_btn_conditioner;

    localparam int N  = 2;
    localparam int D  = 8;
    localparam int RD = 20;
    localparam int RP = 5;

    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;

    always #5 sysclk = ~sysclk;

    btn_conditioner_if #(.N_BTN(N)) bus ();

    btn_conditioner #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: level flips once the synced input has disagreed with it
    // for D straight edges; repeats fall at press+RD+k*RP.
    bit hist [N][D+1];
    bit m_lvl [N];
    bit m_press [N];
    bit m_rel [N];
    bit m_rep [N];
    bit m_step [N];
    int m_pe [N];
    int m_edge;

    int c_pr [N];
    int c_rl [N];
    int c_rp [N];
    int c_st [N];
    int c_hi [N];

    typedef struct {
        logic [1:0] vin;
        int         ncyc;
        logic [1:0] lvl;
        int pr0; int pr1;
        int rl0; int rl1;
        int rp0; int rp1;
        int st0; int st1;
    } row_t;

    row_t rows [5];

    function automatic void model_reset();
        for (int c = 0; c < N; c++) begin
            for (int k = 0; k <= D; k++) hist[c][k] = 1'b0;
            m_lvl[c]   = 1'b0;
            m_press[c] = 1'b0;
            m_rel[c]   = 1'b0;
            m_rep[c]   = 1'b0;
            m_step[c]  = 1'b0;
            m_pe[c]    = 0;
        end
        m_edge = 0;
    endfunction

    function automatic void model_edge(input logic [N-1:0] raw);
        m_edge++;
        for (int c = 0; c < N; c++) begin
            bit prev_st;
            bit all_diff;
            bit rise;
            bit fall;
            int age;
            prev_st  = m_press[c] | m_rep[c];
            all_diff = 1'b1;
            for (int k = 1; k <= D; k++)
                if (hist[c][k] == m_lvl[c]) all_diff = 1'b0;
            rise = all_diff & ~m_lvl[c];
            fall = all_diff & m_lvl[c];
            if (all_diff) m_lvl[c] = ~m_lvl[c];
            if (rise) m_pe[c] = m_edge;
            age = m_edge - m_pe[c];
            m_rep[c] = m_lvl[c] && !rise && (RD != 0) && (age >= RD)
                       && (((age - RD) % RP) == 0);
            m_press[c] = rise;
            m_rel[c]   = fall;
            m_step[c]  = prev_st;
            for (int k = D; k >= 1; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = raw[c];
        end
    endfunction

    task automatic clr_counts();
        for (int c = 0; c < N; c++) begin
            c_pr[c] = 0; c_rl[c] = 0; c_rp[c] = 0;
            c_st[c] = 0; c_hi[c] = 0;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic [N-1:0] v);
        logic [N-1:0] el, ep, er, erp, es;
        bus.btn_in = v;
        @(posedge sysclk);
        model_edge(v);
        #1;
        for (int c = 0; c < N; c++) begin
            el[c] = m_lvl[c];   ep[c]  = m_press[c];
            er[c] = m_rel[c];   erp[c] = m_rep[c];
            es[c] = m_step[c];
        end
        checks++;
        if ({bus.btn_level, bus.btn_press, bus.btn_release,
             bus.btn_repeat, bus.btn_step} !== {el, ep, er, erp, es}) begin
            failures++;
            $display("FAIL cycle t=%0t lvl/prs/rel/rep/stp got %b %b %b %b %b want %b %b %b %b %b",
                     $time, bus.btn_level, bus.btn_press, bus.btn_release,
                     bus.btn_repeat, bus.btn_step, el, ep, er, erp, es);
        end
        for (int c = 0; c < N; c++) begin
            c_pr[c] += int'(bus.btn_press[c]);
            c_rl[c] += int'(bus.btn_release[c]);
            c_rp[c] += int'(bus.btn_repeat[c]);
            c_st[c] += int'(bus.btn_step[c]);
            c_hi[c] += int'(bus.btn_level[c]);
        end
    endtask

    task automatic chk_outs_zero(input string nm);
        chk({nm, "_lvl"}, int'(bus.btn_level), 0);
        chk({nm, "_prs"}, int'(bus.btn_press), 0);
        chk({nm, "_rel"}, int'(bus.btn_release), 0);
        chk({nm, "_rep"}, int'(bus.btn_repeat), 0);
        chk({nm, "_stp"}, int'(bus.btn_step), 0);
    endtask

    initial begin
        logic [N-1:0] rv;
        rows[0] = '{2'b01, 12, 2'b01, 1, 0, 0, 0, 0, 0, 1, 0};
        rows[1] = '{2'b01, 30, 2'b01, 0, 0, 0, 0, 3, 0, 3, 0};
        rows[2] = '{2'b00, 12, 2'b00, 0, 0, 1, 0, 2, 0, 2, 0};
        rows[3] = '{2'b11, 38, 2'b11, 1, 1, 0, 0, 2, 2, 3, 3};
        rows[4] = '{2'b00, 15, 2'b00, 0, 0, 1, 1, 2, 2, 2, 2};

        bus.btn_in = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge sysclk);
        #1;
        chk_outs_zero("reset");
        #3 rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            clr_counts();
            for (int k = 0; k < rows[i].ncyc; k++) cyc(rows[i].vin);
            chk($sformatf("row%0d_lvl", i), int'(bus.btn_level), int'(rows[i].lvl));
            chk($sformatf("row%0d_pr0", i), c_pr[0], rows[i].pr0);
            chk($sformatf("row%0d_pr1", i), c_pr[1], rows[i].pr1);
            chk($sformatf("row%0d_rl0", i), c_rl[0], rows[i].rl0);
            chk($sformatf("row%0d_rl1", i), c_rl[1], rows[i].rl1);
            chk($sformatf("row%0d_rp0", i), c_rp[0], rows[i].rp0);
            chk($sformatf("row%0d_rp1", i), c_rp[1], rows[i].rp1);
            chk($sformatf("row%0d_st0", i), c_st[0], rows[i].st0);
            chk($sformatf("row%0d_st1", i), c_st[1], rows[i].st1);
        end

        // Bounce: toggle channel 0 every 3 cycles for 42 cycles.
        clr_counts();
        for (int i = 0; i < 14; i++)
            repeat (3) cyc((i % 2 == 0) ? 2'b01 : 2'b00);
        repeat (12) cyc(2'b00);
        chk("bounce_hi", c_hi[0], 0);
        chk("bounce_prs", c_pr[0], 0);
        chk("bounce_rel", c_rl[0], 0);

        // Collision: press at edge 10, repeats at 30 and 35,
        // release debounced exactly at edge 35.
        clr_counts();
        repeat (9) cyc(2'b01);
        cyc(2'b01);
        chk("col_press", int'(bus.btn_press[0]), 1);
        repeat (15) cyc(2'b01);
        repeat (9) cyc(2'b00);
        chk("col_rep_before", c_rp[0], 1);
        cyc(2'b00);
        chk("col_rel", int'(bus.btn_release[0]), 1);
        chk("col_rep", int'(bus.btn_repeat[0]), 0);
        chk("col_rep_total", c_rp[0], 1);
        clr_counts();
        repeat (30) cyc(2'b00);
        chk("col_after_rep", c_rp[0], 0);
        // A fresh press must see the full initial delay again.
        clr_counts();
        repeat (29) cyc(2'b01);
        chk("col_idle_norep", c_rp[0], 0);
        cyc(2'b01);
        chk("col_idle_rep", int'(bus.btn_repeat[0]), 1);
        repeat (12) cyc(2'b00);

        // Simultaneous press, then async reset while both are held.
        repeat (9) cyc(2'b11);
        cyc(2'b11);
        chk("sim_press", int'(bus.btn_press), 3);
        repeat (5) cyc(2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk_outs_zero("async_rst");
        repeat (2) @(posedge sysclk);
        #3 rst_n = 1'b1;
        model_reset();
        repeat (9) cyc(2'b11);
        chk("rst_lvl9", int'(bus.btn_level), 0);
        cyc(2'b11);
        chk("rst_press10", int'(bus.btn_press), 3);
        repeat (25) cyc(2'b11);
        repeat (12) cyc(2'b00);

        // Random run against the model.
        rv = '0;
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 13) == 0) rv[c] = ~rv[c];
            cyc(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
